// File: rtl/rs_syndrome_calc.sv
// Reed-Solomon syndrome calculator over GF(2^M).
// Evaluates S_j = r(alpha^(FCR+j)), j = 0..N-K-1, by Horner's rule,
// consuming one received symbol per clock from the highest index down.
module rs_syndrome_calc #(
    parameter int unsigned M         = 4,
    parameter int unsigned N         = 15,
    parameter int unsigned K         = 9,
    parameter logic [M:0]  PRIM_POLY = 5'b10011,
    parameter int unsigned FCR       = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N*M-1:0]         recievedMessageIn,
    input  logic                   startCalc,
    output logic                   busy,
    output logic [(N-K)*M-1:0]     syndromesOut,
    output logic                   syndromesValid,
    output logic                   errorDetected
);

    localparam int unsigned TWO_T = N - K;
    localparam int unsigned CW    = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned ORD   = (1 << M) - 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    // Multiply by alpha^p as p repeated xtime steps; p is a constant at
    // every call site, so this unrolls into a fixed XOR network.
    function automatic logic [M-1:0] mul_alpha_pow(input logic [M-1:0] a,
                                                   input int unsigned p);
        logic [M-1:0] v;
        v = a;
        for (int unsigned i = 0; i < p; i++) begin
            v = {v[M-2:0], 1'b0} ^ (v[M-1] ? PRIM_POLY[M-1:0] : '0);
        end
        return v;
    endfunction

    state_e               state_q, state_d;
    logic [N*M-1:0]       msg_q, msg_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [M-1:0]         acc_q [TWO_T];
    logic [M-1:0]         acc_d [TWO_T];
    logic [TWO_T*M-1:0]   synd_q, synd_d;
    logic                 err_q, err_d;

    logic [M-1:0]         cur_sym;
    logic [M-1:0]         step [TWO_T];
    logic                 step_nonzero;

    assign cur_sym = msg_q[cnt_q*M +: M];

    // One Horner step per syndrome: acc * alpha^(FCR+j) + r[counter].
    for (genvar g = 0; g < TWO_T; g++) begin : g_step
        localparam int unsigned P = (FCR + g) % ORD;
        assign step[g] = mul_alpha_pow(acc_q[g], P) ^ cur_sym;
    end

    // OR of all syndrome bits of the step result, used on the final step.
    always_comb begin
        step_nonzero = 1'b0;
        for (int unsigned j = 0; j < TWO_T; j++) begin
            step_nonzero = step_nonzero | (|step[j]);
        end
    end

    // Next-state and datapath update for IDLE / CALC / DONE.
    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        cnt_d   = cnt_q;
        synd_d  = synd_q;
        err_d   = err_q;
        for (int unsigned j = 0; j < TWO_T; j++) begin
            acc_d[j] = acc_q[j];
        end

        case (state_q)
            IDLE, DONE: begin
                if (startCalc) begin
                    msg_d   = recievedMessageIn;
                    cnt_d   = CW'(N - 1);
                    state_d = CALC;
                    for (int unsigned j = 0; j < TWO_T; j++) begin
                        acc_d[j] = '0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                for (int unsigned j = 0; j < TWO_T; j++) begin
                    acc_d[j] = step[j];
                end
                if (cnt_q == '0) begin
                    state_d = DONE;
                    for (int unsigned j = 0; j < TWO_T; j++) begin
                        synd_d[j*M +: M] = step[j];
                    end
                    err_d = step_nonzero;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: latched codeword, counter, accumulators, outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            msg_q  <= '0;
            cnt_q  <= '0;
            synd_q <= '0;
            err_q  <= 1'b0;
            for (int unsigned j = 0; j < TWO_T; j++) begin
                acc_q[j] <= '0;
            end
        end else begin
            msg_q  <= msg_d;
            cnt_q  <= cnt_d;
            synd_q <= synd_d;
            err_q  <= err_d;
            for (int unsigned j = 0; j < TWO_T; j++) begin
                acc_q[j] <= acc_d[j];
            end
        end
    end

    assign busy           = (state_q == CALC);
    assign syndromesValid = (state_q == DONE);
    assign syndromesOut   = synd_q;
    assign errorDetected  = err_q;

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Testbench for rs_syndrome_calc with default parameters (RS(15,9), GF(16)).
module tb_rs_syndrome_calc;

    localparam int unsigned M   = 4;
    localparam int unsigned N   = 15;
    localparam int unsigned K   = 9;
    localparam int unsigned TT  = N - K;
    localparam int unsigned FCR = 1;

    logic              clk;
    logic              reset;
    logic [N*M-1:0]    recievedMessageIn;
    logic              startCalc;
    logic              busy;
    logic [TT*M-1:0]   syndromesOut;
    logic              syndromesValid;
    logic              errorDetected;

    int unsigned checks;
    int unsigned errors;

    logic [TT*M-1:0]   last_synd;
    logic              last_err;

    int unsigned gexp [15];
    int unsigned glog [16];

    typedef struct {
        logic [N*M-1:0]  word;
        logic [TT*M-1:0] synd;
        logic            err;
    } vec_t;

    vec_t tbl [4];

    rs_syndrome_calc #(
        .M         (M),
        .N         (N),
        .K         (K),
        .PRIM_POLY (5'b10011),
        .FCR       (FCR)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .recievedMessageIn (recievedMessageIn),
        .startCalc         (startCalc),
        .busy              (busy),
        .syndromesOut      (syndromesOut),
        .syndromesValid    (syndromesValid),
        .errorDetected     (errorDetected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // GF(16) power/log tables built from x^4+x+1.
    task automatic build_tables();
        int unsigned v;
        v = 1;
        for (int unsigned i = 0; i < 15; i++) begin
            gexp[i] = v;
            glog[v] = i;
            v = v << 1;
            if ((v & 16) != 0) v = v ^ 32'h13;
        end
    endtask

    // Direct polynomial evaluation: S_j = sum_i r_i * alpha^((FCR+j)*i).
    function automatic logic [TT*M-1:0] ref_synd(input logic [N*M-1:0] w);
        logic [TT*M-1:0] s;
        logic [M-1:0]    acc;
        int unsigned     r;
        s = '0;
        for (int unsigned j = 0; j < TT; j++) begin
            acc = '0;
            for (int unsigned i = 0; i < N; i++) begin
                r = 32'(w[i*M +: M]);
                if (r != 0) acc = acc ^ 4'(gexp[(glog[r] + (FCR + j) * i) % 15]);
            end
            s[j*M +: M] = acc;
        end
        return s;
    endfunction

    // One full request; optionally scrambles inputs during CALC.
    task automatic run_word(input logic [N*M-1:0] w, input logic [TT*M-1:0] es,
                            input logic ee, input bit disturb, input string tag);
        int unsigned lat;
        bit          seen;
        bit          busy_ok;
        bit          hold_ok;
        logic [63:0] rnd;
        recievedMessageIn = w;
        startCalc = 1'b1;
        tick();
        startCalc = 1'b0;
        lat = 0; seen = 0; busy_ok = 1; hold_ok = 1;
        while (lat < 40) begin
            if (syndromesValid) begin
                seen = 1;
                break;
            end
            if (!busy) busy_ok = 0;
            if (syndromesOut !== last_synd || errorDetected !== last_err) hold_ok = 0;
            if (disturb) begin
                rnd = {$urandom(), $urandom()};
                recievedMessageIn = rnd[N*M-1:0];
                startCalc = 1'($urandom_range(0, 1));
            end
            tick();
            lat++;
        end
        startCalc = 1'b0;
        check({tag, "_valid_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'(N));
        check({tag, "_busy_during_calc"}, 64'(busy_ok), 64'd1);
        check({tag, "_outputs_held"}, 64'(hold_ok), 64'd1);
        check({tag, "_syndromes"}, 64'(syndromesOut), 64'(es));
        check({tag, "_error_flag"}, 64'(errorDetected), 64'(ee));
        check({tag, "_busy_at_valid"}, 64'(busy), 64'd0);
        last_synd = es;
        last_err  = ee;
        tick();
        check({tag, "_valid_one_cycle"}, 64'(syndromesValid), 64'd0);
        check({tag, "_idle_after"}, 64'(busy), 64'd0);
        check({tag, "_synd_held_after"}, 64'(syndromesOut), 64'(es));
    endtask

    initial begin
        logic [63:0]     rnd;
        logic [N*M-1:0]  w;
        logic [TT*M-1:0] s;
        int unsigned     cnt;
        bit              spurious;

        checks = 0;
        errors = 0;
        last_synd = '0;
        last_err  = 1'b0;
        build_tables();

        tbl[0] = '{word: 60'h000000001793CAC, synd: 24'h000000, err: 1'b0};
        tbl[1] = '{word: 60'h000000000000010, synd: 24'hC63842, err: 1'b1};
        tbl[2] = '{word: 60'h000000000000011, synd: 24'hD72953, err: 1'b1};
        tbl[3] = '{word: 60'h000000000000000, synd: 24'h000000, err: 1'b0};

        reset = 1'b1;
        startCalc = 1'b0;
        recievedMessageIn = '0;
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_valid", 64'(syndromesValid), 64'd0);
        check("reset_synd", 64'(syndromesOut), 64'd0);
        check("reset_err", 64'(errorDetected), 64'd0);

        // Table vectors, clean inputs then with disturbance during CALC.
        for (int unsigned t = 0; t < 4; t++) begin
            run_word(tbl[t].word, tbl[t].synd, tbl[t].err, 1'b0, $sformatf("tbl%0d", t));
        end
        for (int unsigned t = 0; t < 4; t++) begin
            run_word(tbl[t].word, tbl[t].synd, tbl[t].err, 1'b1, $sformatf("tbl_dist%0d", t));
        end

        // Random words against the direct-evaluation model.
        for (int unsigned t = 0; t < 20; t++) begin
            rnd = {$urandom(), $urandom()};
            w = rnd[N*M-1:0];
            if (t % 4 == 0) w = '0;
            if (t % 4 == 0) w[$urandom_range(0, N-1)*M +: M] = 4'($urandom_range(1, 15));
            s = ref_synd(w);
            run_word(w, s, |s, t[0], $sformatf("rnd%0d", t));
        end

        // Back-to-back: startCalc held high, pulses every N+1 cycles.
        recievedMessageIn = tbl[1].word;
        startCalc = 1'b1;
        tick();
        for (int unsigned p = 0; p < 3; p++) begin
            cnt = 0;
            do begin
                tick();
                cnt++;
            end while (!syndromesValid && cnt < 40);
            check($sformatf("b2b%0d_valid", p), 64'(syndromesValid), 64'd1);
            check($sformatf("b2b%0d_interval", p), 64'(cnt), (p == 0) ? 64'(N) : 64'(N + 1));
            check($sformatf("b2b%0d_synd", p), 64'(syndromesOut), 64'(tbl[1].synd));
            check($sformatf("b2b%0d_err", p), 64'(errorDetected), 64'd1);
        end
        startCalc = 1'b0;
        tick();
        check("b2b_stop_busy", 64'(busy), 64'd0);
        check("b2b_stop_valid", 64'(syndromesValid), 64'd0);
        last_synd = tbl[1].synd;
        last_err  = 1'b1;

        // Reset during CALC abandons the word.
        recievedMessageIn = tbl[2].word;
        startCalc = 1'b1;
        tick();
        startCalc = 1'b0;
        repeat (6) tick();
        check("midreset_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_valid", 64'(syndromesValid), 64'd0);
        check("midreset_synd", 64'(syndromesOut), 64'd0);
        check("midreset_err", 64'(errorDetected), 64'd0);
        spurious = 0;
        repeat (20) begin
            if (syndromesValid || busy) spurious = 1;
            tick();
        end
        check("midreset_no_pulse", 64'(spurious), 64'd0);
        last_synd = '0;
        last_err  = 1'b0;
        run_word(tbl[1].word, tbl[1].synd, tbl[1].err, 1'b0, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
